project_activator: RTL
======================

Name: project_activator

Overview:
- Wishbone-controlled selector that drives the per-project `active` enables of the multi-project user area.
- Replaces the raw LA-driven enables with a safe switchover sequence:
  - all projects deselected for a guard interval, so the shared io_out/io_oeb bus never has two drivers;
  - then the new project is enabled with a reset pulse.
- Sits directly upstream of the wrapped projects in user_project_wrapper.
- An LA override path keeps the existing bring-up method available.

Parameters:
- NUM_PROJECTS, 3, number of wrapped projects, 1..32; width of active.
- BASE_ADDR, 32'h3000_0000, Wishbone base; decodes a 16-byte window.
- GUARD_DEFAULT, 16, reset value of GUARD register, in cycles.
- RST_CYCLES, 4, length of proj_rst pulse in cycles, ≥1.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored, full-word access only.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- la_override  in  1  when 1, active follows la_active.
- la_active  in  32  LA-supplied enables; low NUM_PROJECTS bits used.
- active  out  NUM_PROJECTS  one-hot (or zero) project enables, registered.
- proj_rst  out  1  active-high reset to the newly selected project, registered.

Behaviour:
- Reset (async assert, sync release):
  - active=0, proj_rst=0, wbs_ack_o=0, wbs_dat_o=0.
  - State IDLE; CUR_IDX=0; EN=0; GUARD=GUARD_DEFAULT; ERR=0.
- Decode:
  - Hit when wbs_adr_i[31:4]==BASE_ADDR[31:4].
  - No hit → no ack, module silent.
- Access:
  - A request is accepted on the edge where stb&cyc&hit&~wbs_ack_o.
  - wbs_ack_o is high for exactly the following cycle; back-to-back accesses take 2 cycles each.
  - wbs_dat_o carries read data during ack, else 0.
- Registers (offset by adr[3:2]):
  - 0x0 CTRL, RW:
    - [7:0] target index; [31] enable.
    - A write starts a switch; it is ignored and ERR set if state≠IDLE/RUN.
  - 0x4 STATUS, R:
    - [7:0] CUR_IDX; [8] busy (DRAIN or RESET); [9] a project is active; [10] ERR.
    - Writing bit10=1 clears ERR.
  - 0x8 GUARD, RW: [15:0] guard cycles; 0 treated as 1.
  - 0xC INFO, R: [7:0]=NUM_PROJECTS, [31:16]=16'h5041. Writes ignored.
- FSM:
  - IDLE: active=0.
  - RUN: active=onehot(CUR_IDX).
  - Accepted CTRL write (on edge T):
    - latch target/enable;
    - go to DRAIN;
    - active=0 from cycle T+1.
  - DRAIN:
    - holds max(GUARD,1) cycles.
    - Then, if enable=1 and target<NUM_PROJECTS: CUR_IDX←target, go to RESET.
    - Otherwise go to IDLE; CUR_IDX unchanged, STATUS[9]=0.
  - RESET: active=onehot(CUR_IDX), proj_rst=1 for exactly RST_CYCLES cycles, then RUN.
  - RUN: proj_rst=0; stays until the next CTRL write.
- Edge cases:
  - Writing the currently running index still performs the full DRAIN/RESET sequence.
  - GUARD written during DRAIN takes effect only on the next switch, because the count is latched on entry.
  - Reset mid-sequence returns to IDLE immediately: active=0, proj_rst=0.
- LA override:
  - When la_override=1: active←la_active[NUM_PROJECTS-1:0] (registered, 1-cycle latency) and proj_rst forced 0.
  - The FSM continues internally.
  - On deassert, active returns to the FSM value on the next cycle.

Test Plan:
- Reset then read INFO at 0x3000_000C → 0x5041_0003, ack exactly 1 cycle after the request; all outputs 0 during and after reset.
- GUARD=3; write CTRL=0x8000_0001 → active=0 for 3 cycles, then active=3'b010 with proj_rst=1 for 4 cycles, then proj_rst=0; STATUS reads 0x201.
- From RUN idx1, write CTRL=0x8000_0002 → active 010→000 for 3 cycles→100, with no cycle having two bits set.
- During DRAIN, write CTRL=0x8000_0000 → ignored, STATUS[10]=1, switch completes to the original target; writing STATUS 0x400 clears ERR.
- Write CTRL=0x8000_0007 (idx≥NUM_PROJECTS) or 0x0000_0001 → DRAIN then IDLE, active=0, STATUS[9]=0.
- la_override=1, la_active=0x5 → active=3'b101 one cycle later, proj_rst=0; drop override → FSM value restored. Separately, assert wb_rst_i mid-RESET → active=0, proj_rst=0 asynchronously.

Source files
------------

// File: rtl/project_activator.sv
// Wishbone-controlled project selector: break-before-make switchover of the
// per-project active enables, with a reset pulse to the newly selected project.
module project_activator #(
    parameter int          NUM_PROJECTS  = 3,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          GUARD_DEFAULT = 16,
    parameter int          RST_CYCLES    = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    input  logic                    la_override,
    input  logic [31:0]             la_active,
    output logic [NUM_PROJECTS-1:0] active,
    output logic                    proj_rst
);

    typedef enum logic [1:0] {IDLE, DRAIN, RESET, RUN} state_t;

    state_t                  state, state_next;
    logic [7:0]              cur_idx, target, idx_next;
    logic                    en, err;
    logic [15:0]             guard, cnt;
    logic                    hit, req, ctrl_wr, start, cnt_done, tgt_ok;
    logic [31:0]             rd_data;
    logic [NUM_PROJECTS-1:0] active_d;
    logic                    proj_rst_d;
    logic                    unused_bits;

    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i, la_active};

    assign hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req      = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
    assign ctrl_wr  = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign start    = ctrl_wr & ((state == IDLE) || (state == RUN));
    assign cnt_done = (cnt <= 16'd1);
    assign tgt_ok   = en && (target < 8'(NUM_PROJECTS));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN: if (start) state_next = DRAIN;
            DRAIN:     if (cnt_done) state_next = tgt_ok ? RESET : IDLE;
            RESET:     if (cnt_done) state_next = RUN;
            default:   state_next = IDLE;
        endcase
    end

    // Index that will be current after this edge, so the registered enables
    // line up with the state they belong to.
    always_comb begin
        idx_next   = (state == DRAIN && state_next == RESET) ? target : cur_idx;
        active_d   = '0;
        proj_rst_d = 1'b0;
        if (state_next == RESET || state_next == RUN)
            active_d = NUM_PROJECTS'(1) << idx_next;
        if (state_next == RESET)
            proj_rst_d = 1'b1;
        if (la_override) begin
            active_d   = la_active[NUM_PROJECTS-1:0];
            proj_rst_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            active   <= '0;
            proj_rst <= 1'b0;
        end else begin
            active   <= active_d;
            proj_rst <= proj_rst_d;
        end
    end

    // Guard count is latched on DRAIN entry; later GUARD writes affect the next switch.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cur_idx <= '0;
            target  <= '0;
            en      <= 1'b0;
            err     <= 1'b0;
            guard   <= 16'(GUARD_DEFAULT);
            cnt     <= '0;
        end else begin
            if (start) begin
                target <= wbs_dat_i[7:0];
                en     <= wbs_dat_i[31];
                cnt    <= (guard == 16'd0) ? 16'd1 : guard;
            end else if (state == DRAIN && cnt_done) begin
                if (tgt_ok) begin
                    cur_idx <= target;
                    cnt     <= 16'(RST_CYCLES);
                end
            end else if ((state == DRAIN || state == RESET) && !cnt_done) begin
                cnt <= cnt - 16'd1;
            end

            if (ctrl_wr && !start)
                err <= 1'b1;
            else if (req && wbs_we_i && wbs_adr_i[3:2] == 2'd1 && wbs_dat_i[10])
                err <= 1'b0;

            if (req && wbs_we_i && wbs_adr_i[3:2] == 2'd2)
                guard <= wbs_dat_i[15:0];
        end
    end

    always_comb begin
        rd_data = '0;
        case (wbs_adr_i[3:2])
            2'd0: rd_data = {en, 23'd0, target};
            2'd1: rd_data = {21'd0, err, (state == RESET || state == RUN),
                             (state == DRAIN || state == RESET), cur_idx};
            2'd2: rd_data = {16'd0, guard};
            2'd3: rd_data = {16'h5041, 8'd0, 8'(NUM_PROJECTS)};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;
        end
    end

endmodule
